// File: rtl/logicalunit_prober_pkg.sv
// Shared definitions for the logical-unit prober: FSM encodings, vector indices and
// the settle-counter width helper.
package logicalunit_prober_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StSettle = 3'd1,
    StSamp0  = 3'd2,
    StSamp1  = 3'd3,
    StDone   = 3'd4
  } state_e;

  // Vector index = {a,b}; also the func_found bit position for that vector.
  localparam logic [1:0] VEC_00 = 2'd0;
  localparam logic [1:0] VEC_01 = 2'd1;
  localparam logic [1:0] VEC_10 = 2'd2;
  localparam logic [1:0] VEC_11 = 2'd3;

  function automatic int unsigned settle_cnt_width(input int unsigned cycles);
    int unsigned w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/logicalunit_prober_if.sv
// Controller/unit-facing signal bundle of the prober; slave is the prober side,
// master the controller plus logical unit.
interface logicalunit_prober_if;

  logic       start;
  logic [3:0] expected;
  logic       probe_a;
  logic       probe_b;
  logic       probe_out;
  logic       busy;
  logic       done;
  logic [3:0] func_found;
  logic       match;
  logic       unstable;

  modport slave (
    input  start,
    input  expected,
    input  probe_out,
    output probe_a,
    output probe_b,
    output busy,
    output done,
    output func_found,
    output match,
    output unstable
  );

  modport master (
    output start,
    output expected,
    output probe_out,
    input  probe_a,
    input  probe_b,
    input  busy,
    input  done,
    input  func_found,
    input  match,
    input  unstable
  );

endinterface

// File: rtl/logicalunit_prober_settle_timer.sv
// Settle down-counter: load on SETTLE entry, count down while enabled, flag at zero.
module logicalunit_prober_settle_timer
  import logicalunit_prober_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic zero
);

  localparam int unsigned CntW    = settle_cnt_width(SETTLE_CYCLES);
  // Loading N-1 makes the zero flag mark the last of N settle cycles.
  localparam int unsigned LoadInt = (SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1;
  localparam logic [CntW-1:0] LoadVal = CntW'(LoadInt);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LoadVal;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/logicalunit_prober.sv
// Reader side of the 2-input logical unit: walks a/b through all four vectors, samples
// the unit output twice per vector and recovers/compares its 4-bit func word.
module logicalunit_prober
  import logicalunit_prober_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic                 clk,
  input logic                 rst,
  logicalunit_prober_if.slave bus
);

  localparam bit SkipSettle = (SETTLE_CYCLES == 0);

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic       s0_q, s0_d;
  logic [3:0] exp_q, exp_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [3:0] func_q, func_d;
  logic       match_q, match_d;
  logic       unst_q, unst_d;

  logic timer_load;
  logic timer_en;
  logic timer_zero;

  logicalunit_prober_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .en   (timer_en),
    .zero (timer_zero)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    s0_d       = s0_q;
    exp_d      = exp_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    func_d     = func_q;
    match_d    = match_q;
    unst_d     = unst_q;
    timer_load = 1'b0;
    timer_en   = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          exp_d   = bus.expected;
          func_d  = '0;
          match_d = 1'b0;
          unst_d  = 1'b0;
          busy_d  = 1'b1;
          idx_d   = VEC_00;
          if (SkipSettle) begin
            state_d = StSamp0;
          end else begin
            state_d    = StSettle;
            timer_load = 1'b1;
          end
        end
      end

      StSettle: begin
        timer_en = 1'b1;
        if (timer_zero) begin
          state_d = StSamp0;
        end
      end

      StSamp0: begin
        s0_d    = bus.probe_out;
        state_d = StSamp1;
      end

      StSamp1: begin
        func_d[idx_q] = bus.probe_out;
        if (s0_q != bus.probe_out) begin
          unst_d = 1'b1;
        end
        if (idx_q == VEC_11) begin
          // Probes keep the {1,1} vector; only the status flags change here.
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          match_d = (func_d == exp_q) && !unst_d;
        end else begin
          idx_d = idx_q + 2'd1;
          if (SkipSettle) begin
            state_d = StSamp0;
          end else begin
            state_d    = StSettle;
            timer_load = 1'b1;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= VEC_00;
      s0_q    <= 1'b0;
      exp_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      func_q  <= '0;
      match_q <= 1'b0;
      unst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      s0_q    <= s0_d;
      exp_q   <= exp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      func_q  <= func_d;
      match_q <= match_d;
      unst_q  <= unst_d;
    end
  end

  // The vector index register doubles as the probe drive, so probes are registered.
  assign bus.probe_a    = idx_q[1];
  assign bus.probe_b    = idx_q[0];
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.func_found = func_q;
  assign bus.match      = match_q;
  assign bus.unstable   = unst_q;

endmodule

// File: tb/tb_logicalunit_prober.sv
// Directed bench: two probers (settle 2 and settle 0) each wired to a logical-unit model.
module tb_logicalunit_prober;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logicalunit_prober_if b2 ();
  logicalunit_prober_if b0 ();

  logic       start_v;
  logic       sel0;
  logic [3:0] func_v;
  logic [3:0] exp_v;
  logic       ov_en;
  logic       ov_val;

  int n_checks = 0;
  int n_fail   = 0;

  assign b2.start     = start_v & ~sel0;
  assign b0.start     = start_v & sel0;
  assign b2.expected  = exp_v;
  assign b0.expected  = exp_v;
  assign b2.probe_out = ov_en ? ov_val : func_v[{b2.probe_a, b2.probe_b}];
  assign b0.probe_out = func_v[{b0.probe_a, b0.probe_b}];

  logicalunit_prober #(.SETTLE_CYCLES(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (b2)
  );

  logicalunit_prober #(.SETTLE_CYCLES(0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  wire       busy_s  = sel0 ? b0.busy : b2.busy;
  wire       done_s  = sel0 ? b0.done : b2.done;
  wire       pa_s    = sel0 ? b0.probe_a : b2.probe_a;
  wire       pb_s    = sel0 ? b0.probe_b : b2.probe_b;
  wire [3:0] ff_s    = sel0 ? b0.func_found : b2.func_found;
  wire       match_s = sel0 ? b0.match : b2.match;
  wire       unst_s  = sel0 ? b0.unstable : b2.unstable;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_probes"}, {30'd0, pa_s, pb_s}, 32'd0);
    check({tag, "_busy"}, busy_s, 0);
    check({tag, "_done"}, done_s, 0);
    check({tag, "_func"}, ff_s, 0);
    check({tag, "_match"}, match_s, 0);
    check({tag, "_unstable"}, unst_s, 0);
  endtask

  // Starts a run and returns at the negedge of the DONE cycle (or on timeout).
  task automatic run_probe(input bit use0, input int settle, input logic [3:0] fn,
                           input logic [3:0] ex, input int inst_vec, input int pulse_at,
                           input bit hold, output int busy_cnt, output int done_cnt);
    int k;
    int probe_bad;
    bit got_done;
    int s0k;
    sel0      = use0;
    func_v    = fn;
    exp_v     = ex;
    ov_en     = 1'b0;
    busy_cnt  = 0;
    done_cnt  = 0;
    probe_bad = 0;
    got_done  = 1'b0;
    k         = 0;
    s0k       = inst_vec * (settle + 2) + settle;
    @(negedge clk);
    start_v = 1'b1;
    while (!got_done && k < 200) begin
      @(negedge clk);
      if (!hold) start_v = (k == pulse_at);
      if (busy_s) begin
        busy_cnt++;
        if ({pa_s, pb_s} != 2'(k / (settle + 2))) probe_bad++;
      end
      if (done_s) begin
        done_cnt++;
        got_done = 1'b1;
      end
      if (inst_vec >= 0 && k == s0k) begin
        ov_en  = 1'b1;
        ov_val = 1'b0;
      end else if (inst_vec >= 0 && k == s0k + 1) begin
        ov_val = 1'b1;
      end else begin
        ov_en = 1'b0;
      end
      k++;
    end
    check("run_done_seen", got_done, 1);
    check("probe_sequence_errors", probe_bad, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    int dc;
    int extra_done;
    int extra_busy;
    int n;
    rst     = 1'b1;
    start_v = 1'b0;
    sel0    = 1'b0;
    func_v  = 4'b0000;
    exp_v   = 4'b0000;
    ov_en   = 1'b0;
    ov_val  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset2");
    sel0 = 1'b1;
    check_reset("reset0");
    sel0 = 1'b0;
    rst  = 1'b0;

    // XOR, settle 2
    run_probe(0, 2, 4'b0110, 4'b0110, -1, -1, 0, bc, dc);
    check("xor_busy_cycles", bc, 16);
    check("xor_done_pulses", dc, 1);
    check("xor_func", ff_s, 4'b0110);
    check("xor_match", match_s, 1);
    check("xor_unstable", unst_s, 0);
    @(negedge clk);
    check("xor_done_one_cycle", done_s, 0);
    check("xor_idle_busy", busy_s, 0);
    check("xor_func_held", ff_s, 4'b0110);
    check("xor_probes_hold_11", {30'd0, pa_s, pb_s}, 32'd3);

    // AND against wrong expectation
    run_probe(0, 2, 4'b1000, 4'b1110, -1, -1, 0, bc, dc);
    check("and_func", ff_s, 4'b1000);
    check("and_match", match_s, 0);
    check("and_unstable", unst_s, 0);

    // Zero settle
    run_probe(1, 0, 4'b1111, 4'b1111, -1, -1, 0, bc, dc);
    check("zs_busy_cycles", bc, 8);
    check("zs_func", ff_s, 4'b1111);
    check("zs_match", match_s, 1);

    // Instability on vector 2
    run_probe(0, 2, 4'b0000, 4'b0100, 2, -1, 0, bc, dc);
    check("inst_unstable", unst_s, 1);
    check("inst_func", ff_s, 4'b0100);
    check("inst_match", match_s, 0);

    // start pulsed mid-run is ignored
    run_probe(0, 2, 4'b0110, 4'b0110, -1, 5, 0, bc, dc);
    check("ign_busy_cycles", bc, 16);
    check("ign_done_pulses", dc, 1);
    extra_done = 0;
    extra_busy = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_s) extra_done++;
      if (busy_s) extra_busy++;
    end
    check("ign_extra_done", extra_done, 0);
    check("ign_extra_busy", extra_busy, 0);

    // start held high: back-to-back runs with one idle cycle
    run_probe(0, 2, 4'b1001, 4'b1001, -1, -1, 1, bc, dc);
    check("held_first_func", ff_s, 4'b1001);
    @(negedge clk);
    check("held_gap_busy", busy_s, 0);
    check("held_gap_done", done_s, 0);
    @(negedge clk);
    start_v = 1'b0;
    check("held_restart_busy", busy_s, 1);
    check("held_restart_cleared", ff_s, 4'b0000);
    bc = 1;
    n  = 0;
    while (!done_s && n < 40) begin
      @(negedge clk);
      if (busy_s) bc++;
      n++;
    end
    check("held_second_done", done_s, 1);
    check("held_second_busy", bc, 16);
    check("held_second_match", match_s, 1);

    // Reset in SAMP0 of vector 1
    sel0   = 1'b0;
    func_v = 4'b1111;
    exp_v  = 4'b1111;
    @(negedge clk);
    start_v = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      start_v = 1'b0;
    end
    check("rst_partial_func", ff_s, 4'b0001);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset("midrst");
    extra_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_s) extra_done++;
    end
    check("midrst_no_done", extra_done, 0);
    run_probe(0, 2, 4'b0011, 4'b0011, -1, -1, 0, bc, dc);
    check("post_rst_busy", bc, 16);
    check("post_rst_func", ff_s, 4'b0011);
    check("post_rst_match", match_s, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
